// File: rtl/rx9_lane_deskew80.sv
// rtl/rx9_lane_deskew80.sv - 9-lane marker-based deskew and word aligner
//
// Finds MARKER independently on each lane, buffers early lanes in per-lane
// FIFOs so all nine lanes leave word-aligned, and retrains whenever a later
// marker row arrives misaligned.
//
// Ports:
//   I_clk, I_rst             clock, synchronous active-high reset
//   I_enable                 front end locked; low forces IDLE
//   I_vld, I_d0_p..I_d8_p    one 80-bit word per lane per valid beat
//   O_q0_p..O_q8_p, O_vld    aligned lane words and their strobe
//   O_aligned                deskew achieved and holding
//   O_align_err, O_err_cnt   failure pulse and saturating failure count
//   O_lane_skew              per-lane FIFO delay, lane i at [i*SKEW_W +: SKEW_W]

module rx9_lane_deskew80 #(
  parameter logic [79:0] MARKER = 80'hBC5A_0F0F_C3C3_A5A5_5A5A,
  parameter int          SKEW_W = 2
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_enable,
  input  logic                  I_vld,
  input  logic [79:0]           I_d0_p,
  input  logic [79:0]           I_d1_p,
  input  logic [79:0]           I_d2_p,
  input  logic [79:0]           I_d3_p,
  input  logic [79:0]           I_d4_p,
  input  logic [79:0]           I_d5_p,
  input  logic [79:0]           I_d6_p,
  input  logic [79:0]           I_d7_p,
  input  logic [79:0]           I_d8_p,
  output logic [79:0]           O_q0_p,
  output logic [79:0]           O_q1_p,
  output logic [79:0]           O_q2_p,
  output logic [79:0]           O_q3_p,
  output logic [79:0]           O_q4_p,
  output logic [79:0]           O_q5_p,
  output logic [79:0]           O_q6_p,
  output logic [79:0]           O_q7_p,
  output logic [79:0]           O_q8_p,
  output logic                  O_vld,
  output logic                  O_aligned,
  output logic                  O_align_err,
  output logic [7:0]            O_err_cnt,
  output logic [9*SKEW_W-1:0]   O_lane_skew
);

  localparam int LANES = 9;
  localparam int DEPTH = 2 ** SKEW_W;

  typedef enum logic [1:0] {IDLE, SEARCH, ALIGNED} state_t;

  state_t              state;
  logic [79:0]         d_arr   [LANES];
  logic [79:0]         q_arr   [LANES];
  logic [79:0]         mem     [LANES][DEPTH];
  logic [SKEW_W-1:0]   rd_ptr  [LANES];
  logic [SKEW_W-1:0]   wr_idx  [LANES];
  logic [SKEW_W:0]     occ     [LANES];
  logic [LANES-1:0]    seen;
  logic [SKEW_W-1:0]   cnt;

  logic [LANES-1:0]    seen_nxt;
  logic [LANES-1:0]    head_is_marker;
  logic [SKEW_W-1:0]   cnt_nxt;
  logic                search_beat, align_beat;
  logic                search_done, search_fail, align_fail, fail;

  assign d_arr[0] = I_d0_p;
  assign d_arr[1] = I_d1_p;
  assign d_arr[2] = I_d2_p;
  assign d_arr[3] = I_d3_p;
  assign d_arr[4] = I_d4_p;
  assign d_arr[5] = I_d5_p;
  assign d_arr[6] = I_d6_p;
  assign d_arr[7] = I_d7_p;
  assign d_arr[8] = I_d8_p;

  assign O_q0_p = q_arr[0];
  assign O_q1_p = q_arr[1];
  assign O_q2_p = q_arr[2];
  assign O_q3_p = q_arr[3];
  assign O_q4_p = q_arr[4];
  assign O_q5_p = q_arr[5];
  assign O_q6_p = q_arr[6];
  assign O_q7_p = q_arr[7];
  assign O_q8_p = q_arr[8];

  always_comb begin
    seen_nxt       = seen;
    head_is_marker = '0;
    for (int i = 0; i < LANES; i++) begin
      if (d_arr[i] == MARKER) seen_nxt[i] = 1'b1;
      head_is_marker[i] = (mem[i][rd_ptr[i]] == MARKER);
      // Tail slot; when the FIFO is full it aliases the head, which is read
      // before being overwritten on the same edge.
      wr_idx[i] = rd_ptr[i] + occ[i][SKEW_W-1:0];
    end
    // The beat on which the first marker lands leaves cnt at 0.
    cnt_nxt     = (|seen) ? cnt + SKEW_W'(1) : cnt;
    search_beat = I_enable && I_vld && (state == SEARCH);
    align_beat  = I_enable && I_vld && (state == ALIGNED);
    search_done = search_beat && (&seen_nxt);
    search_fail = search_beat && !(&seen_nxt) && (|seen_nxt) &&
                  (cnt_nxt == SKEW_W'(DEPTH - 1));
    align_fail  = align_beat && head_is_marker[0] && !(&head_is_marker[LANES-1:1]);
    fail        = search_fail || align_fail;
  end

  // Storage only; validity is tracked by rd_ptr/occ.
  always_ff @(posedge I_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (align_beat || (search_beat && seen_nxt[i])) mem[i][wr_idx[i]] <= d_arr[i];
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state       <= IDLE;
      seen        <= '0;
      cnt         <= '0;
      O_vld       <= 1'b0;
      O_aligned   <= 1'b0;
      O_align_err <= 1'b0;
      O_err_cnt   <= '0;
      O_lane_skew <= '0;
      for (int i = 0; i < LANES; i++) begin
        rd_ptr[i] <= '0;
        occ[i]    <= '0;
        q_arr[i]  <= '0;
      end
    end else begin
      O_vld       <= align_beat;
      O_align_err <= fail;
      if (fail && (O_err_cnt != 8'hFF)) O_err_cnt <= O_err_cnt + 8'd1;

      if (align_beat) begin
        for (int i = 0; i < LANES; i++) q_arr[i] <= mem[i][rd_ptr[i]];
      end

      if (!I_enable) begin
        state     <= IDLE;
        O_aligned <= 1'b0;
      end else begin
        case (state)
          IDLE:    state <= SEARCH;
          SEARCH:  if (search_done) begin
                     state     <= ALIGNED;
                     O_aligned <= 1'b1;
                     // All lanes write this beat, so occupancy-after minus 1
                     // equals the occupancy before the write.
                     for (int i = 0; i < LANES; i++)
                       O_lane_skew[i*SKEW_W +: SKEW_W] <= occ[i][SKEW_W-1:0];
                   end
          ALIGNED: if (align_fail) begin
                     state     <= SEARCH;
                     O_aligned <= 1'b0;
                   end
          default: state <= IDLE;
        endcase
      end

      if (!I_enable || fail) begin
        seen <= '0;
        cnt  <= '0;
        for (int i = 0; i < LANES; i++) begin
          rd_ptr[i] <= '0;
          occ[i]    <= '0;
        end
      end else if (search_beat) begin
        seen <= seen_nxt;
        cnt  <= cnt_nxt;
        for (int i = 0; i < LANES; i++)
          if (seen_nxt[i]) occ[i] <= occ[i] + (SKEW_W+1)'(1);
      end else if (align_beat) begin
        for (int i = 0; i < LANES; i++) rd_ptr[i] <= rd_ptr[i] + SKEW_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx9_lane_deskew80.sv
// tb/tb_rx9_lane_deskew80.sv - randomized self-checking bench for rx9_lane_deskew80

module tb_rx9_lane_deskew80;

  localparam logic [79:0] M     = 80'hBC5A_0F0F_C3C3_A5A5_5A5A;
  localparam int          SW    = 2;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en, vld;
  logic [79:0] d [9];
  logic [79:0] q [9];
  logic        o_vld, o_aligned, o_err;
  logic [7:0]  o_cnt;
  logic [17:0] o_skew;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rx9_lane_deskew80 #(.MARKER(M), .SKEW_W(SW)) dut (
    .I_clk(clk), .I_rst(rst), .I_enable(en), .I_vld(vld),
    .I_d0_p(d[0]), .I_d1_p(d[1]), .I_d2_p(d[2]), .I_d3_p(d[3]), .I_d4_p(d[4]),
    .I_d5_p(d[5]), .I_d6_p(d[6]), .I_d7_p(d[7]), .I_d8_p(d[8]),
    .O_q0_p(q[0]), .O_q1_p(q[1]), .O_q2_p(q[2]), .O_q3_p(q[3]), .O_q4_p(q[4]),
    .O_q5_p(q[5]), .O_q6_p(q[6]), .O_q7_p(q[7]), .O_q8_p(q[8]),
    .O_vld(o_vld), .O_aligned(o_aligned), .O_align_err(o_err),
    .O_err_cnt(o_cnt), .O_lane_skew(o_skew)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: per-lane queues, mode 0=idle 1=search 2=aligned,
  // span = beats elapsed since the first marker, inclusive.
  int          m_mode;
  logic [79:0] fq [9][$];
  bit          m_seen [9];
  int          m_span;
  logic [79:0] e_q [9];
  bit          e_vld, e_aligned, e_err;
  logic [7:0]  e_cnt;
  logic [17:0] e_skew;

  function automatic void model_clear();
    for (int i = 0; i < 9; i++) begin
      fq[i].delete();
      m_seen[i] = 0;
    end
    m_span = 0;
  endfunction

  function automatic void model_fail();
    e_err = 1;
    if (e_cnt < 8'd255) e_cnt = e_cnt + 8'd1;
    model_clear();
  endfunction

  function automatic void model_step();
    bit any, all, bad;
    if (rst) begin
      m_mode = 0; model_clear();
      for (int i = 0; i < 9; i++) e_q[i] = '0;
      e_vld = 0; e_aligned = 0; e_err = 0; e_cnt = 0; e_skew = 0;
      return;
    end
    e_vld = 0; e_err = 0;
    if (!en) begin
      m_mode = 0; model_clear(); e_aligned = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1 && vld) begin
      any = 0; all = 1;
      for (int i = 0; i < 9; i++) begin
        if (d[i] == M) m_seen[i] = 1;
        if (m_seen[i]) fq[i].push_back(d[i]);
        any |= m_seen[i];
        all &= m_seen[i];
      end
      if (any) m_span++;
      if (all) begin
        m_mode = 2; e_aligned = 1;
        for (int i = 0; i < 9; i++) e_skew[i*SW +: SW] = SW'(fq[i].size() - 1);
      end else if (any && m_span == DEPTH) begin
        model_fail();
      end
    end else if (m_mode == 2 && vld) begin
      bad = 0;
      for (int i = 0; i < 9; i++) begin
        e_q[i] = fq[i].pop_front();
        fq[i].push_back(d[i]);
      end
      e_vld = 1;
      if (e_q[0] == M)
        for (int i = 1; i < 9; i++) if (e_q[i] != M) bad = 1;
      if (bad) begin
        model_fail(); m_mode = 1; e_aligned = 0;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("vld", 80'(o_vld), 80'(e_vld));
    check("aligned", 80'(o_aligned), 80'(e_aligned));
    check("align_err", 80'(o_err), 80'(e_err));
    check("err_cnt", 80'(o_cnt), 80'(e_cnt));
    check("lane_skew", 80'(o_skew), 80'(e_skew));
    if (e_vld)
      for (int i = 0; i < 9; i++) check($sformatf("q%0d", i), q[i], e_q[i]);
  endtask

  function automatic logic [79:0] rnd80();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  // One valid beat, sometimes preceded by one or two idle cycles.
  task automatic vbeat();
    if ($urandom_range(0, 3) == 0) begin
      vld = 0;
      repeat ($urandom_range(1, 2)) tick();
    end
    vld = 1;
    tick();
    vld = 0;
  endtask

  task automatic restart();
    en = 0; vld = 0; tick();
    en = 1; tick();
  endtask

  // Beats b0..b1-1: lane i sends random data before beat dly[i], MARKER at it,
  // then a lane-tagged counter of beats since its marker.
  task automatic run_train(input int dly[9], input int b0, input int b1);
    for (int b = b0; b < b1; b++) begin
      for (int i = 0; i < 9; i++) begin
        if (b < dly[i])       d[i] = rnd80();
        else if (b == dly[i]) d[i] = M;
        else                  d[i] = {8'(i), 8'h00, 64'(b - dly[i])};
      end
      vbeat();
    end
  endtask

  initial begin
    int dly[9];
    int mx;
    logic [17:0] xs;

    rst = 1; en = 0; vld = 0;
    for (int i = 0; i < 9; i++) d[i] = '0;
    tick(); tick();
    check("rst_vld", 80'(o_vld), 80'd0);
    check("rst_aligned", 80'(o_aligned), 80'd0);
    check("rst_err", 80'(o_err), 80'd0);
    check("rst_cnt", 80'(o_cnt), 80'd0);
    check("rst_skew", 80'(o_skew), 80'd0);
    for (int i = 0; i < 9; i++) check($sformatf("rst_q%0d", i), q[i], 80'd0);
    rst = 0;

    // Zero skew
    restart();
    for (int i = 0; i < 9; i++) dly[i] = 0;
    run_train(dly, 0, 1);
    check("zs_aligned", 80'(o_aligned), 80'd1);
    check("zs_skew", 80'(o_skew), 80'd0);
    run_train(dly, 1, 2);
    check("zs_first_vld", 80'(o_vld), 80'd1);
    for (int i = 0; i < 9; i++) check($sformatf("zs_first_q%0d", i), q[i], M);
    run_train(dly, 2, 10);

    // Skew 2/1/0
    restart();
    for (int i = 0; i < 9; i++) dly[i] = 0;
    dly[3] = 2; dly[7] = 1;
    run_train(dly, 0, 3);
    check("sk_aligned", 80'(o_aligned), 80'd1);
    for (int i = 0; i < 9; i++) xs[i*SW +: SW] = SW'(2 - dly[i]);
    check("sk_skew", 80'(o_skew), 80'(xs));
    run_train(dly, 3, 12);

    // Overflow, then recovery with zero skew
    restart();
    for (int i = 0; i < 9; i++) dly[i] = 0;
    dly[5] = 4;
    run_train(dly, 0, 4);
    check("ov_err", 80'(o_err), 80'd1);
    check("ov_cnt", 80'(o_cnt), 80'd1);
    check("ov_aligned", 80'(o_aligned), 80'd0);
    vld = 0; tick();
    check("ov_err_one_cycle", 80'(o_err), 80'd0);
    for (int i = 0; i < 9; i++) dly[i] = 0;
    run_train(dly, 0, 3);
    check("ov_realign", 80'(o_aligned), 80'd1);

    // Broken alignment: marker row missing on lane 2
    for (int i = 0; i < 9; i++) d[i] = (i == 2) ? rnd80() : M;
    vbeat();
    for (int i = 0; i < 9; i++) d[i] = rnd80();
    vbeat();
    check("br_vld", 80'(o_vld), 80'd1);
    check("br_q0", q[0], M);
    check("br_err", 80'(o_err), 80'd1);
    check("br_aligned", 80'(o_aligned), 80'd0);
    check("br_cnt", 80'(o_cnt), 80'd2);
    run_train(dly, 0, 3);
    check("br_realign", 80'(o_aligned), 80'd1);

    // Enable drop on the same beat as an overflow failure
    restart();
    dly[5] = 4;
    run_train(dly, 0, 3);
    for (int i = 0; i < 9; i++) d[i] = (i == 5) ? rnd80() : {8'(i), 8'h00, 64'd3};
    en = 0; vld = 1; tick(); vld = 0;
    check("ab_err", 80'(o_err), 80'd0);
    check("ab_cnt", 80'(o_cnt), 80'd2);
    check("ab_aligned", 80'(o_aligned), 80'd0);
    en = 1; tick();

    // Randomized marker schedules, some beyond the tolerated skew
    for (int r = 0; r < 25; r++) begin
      restart();
      mx = 0;
      for (int i = 0; i < 9; i++) begin
        dly[i] = $urandom_range(0, 4);
        if (dly[i] > mx) mx = dly[i];
      end
      run_train(dly, 0, mx + 8);
    end

    // Reset in the middle of ALIGNED
    restart();
    for (int i = 0; i < 9; i++) dly[i] = $urandom_range(0, 2);
    run_train(dly, 0, 6);
    rst = 1; vld = 1; tick(); vld = 0;
    check("mr_vld", 80'(o_vld), 80'd0);
    check("mr_aligned", 80'(o_aligned), 80'd0);
    check("mr_cnt", 80'(o_cnt), 80'd0);
    check("mr_skew", 80'(o_skew), 80'd0);
    for (int i = 0; i < 9; i++) check($sformatf("mr_q%0d", i), q[i], 80'd0);
    rst = 0;

    // Saturation: lane 8 never sends a marker
    restart();
    for (int i = 0; i < 9; i++) dly[i] = 0;
    dly[8] = 1000;
    for (int k = 0; k < 260; k++) run_train(dly, 0, 4);
    check("sat_cnt", 80'(o_cnt), 80'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx9_lane_deskew80.md
# rx9_lane_deskew80

Lane deskew and word aligner sitting directly downstream of the 9-lane LVDS receive front end. It takes the nine per-lane 80-bit words (and the front end's data-locked indication), locates a training MARKER word independently on each lane, and absorbs inter-lane skew of up to DEPTH-1 words in per-lane FIFOs. Once aligned, it presents all nine lanes word-aligned on one valid strobe to the link layer. It keeps checking alignment on every subsequent marker and retrains on mismatch.

## Interface
Parameters:
- MARKER, 80'hBC5A_0F0F_C3C3_A5A5_5A5A: training/alignment word expected on every lane.
- SKEW_W, 2: skew index width; DEPTH = 2**SKEW_W words per lane FIFO, max tolerated skew DEPTH-1.

Ports (one clock; reset is synchronous and active-high):
- I_clk  in  1  sole clock; all logic on rising edge.
- I_rst  in  1  synchronous active-high reset.
- I_enable  in  1  front end data-locked; low forces IDLE.
- I_vld  in  1  one new word on every lane this cycle.
- I_d0_p … I_d8_p  in  80 each  lane words.
- O_q0_p … O_q8_p  out  80 each  aligned lane words.
- O_vld  out  1  O_q* valid this cycle.
- O_aligned  out  1  deskew achieved and holding.
- O_align_err  out  1  one-cycle pulse per alignment failure.
- O_err_cnt  out  8  saturating failure count.
- O_lane_skew  out  9*SKEW_W  per-lane FIFO delay (lane i at [i*SKEW_W +: SKEW_W]).

## Operation
- States: IDLE, SEARCH, ALIGNED. Per lane: seen[i], FIFO of DEPTH×80. Shared beat counter cnt (SKEW_W bits).
- IDLE: FIFOs empty, seen=0, cnt=0. I_enable=1 → SEARCH next cycle.
- SEARCH, on I_vld:
  - Lane with seen=0 and I_d{i}==MARKER sets seen[i] and writes the word. Lanes already seen write every beat. Lanes not yet seen write nothing.
  - cnt increments on every beat after the first seen. The beat where the first lane sees the marker leaves cnt=0.
  - If after this beat all nine seen → ALIGNED. O_lane_skew[i] latched = FIFO occupancy of lane i minus 1.
  - Else if some lane seen and cnt==DEPTH-1: failure. Clear FIFOs, seen and cnt, pulse O_align_err, O_err_cnt+1, stay SEARCH.
- ALIGNED: on I_vld, every lane writes I_d{i} and pops its head simultaneously, so occupancy stays constant. Popped heads register onto O_q*, with O_vld=1 for one cycle.
  - Check: if popped lane-0 head == MARKER and any other popped head != MARKER, that is a failure. O_q/O_vld still issue that beat. Then pulse O_align_err, increment the count, clear state, return to SEARCH, and set O_aligned=0.
- MARKER appearing later on an already-seen lane in SEARCH is ordinary data.
- I_vld=0: no state change, no writes/reads, O_vld=0.
- I_enable low in any state → IDLE next cycle. This takes priority over a same-cycle failure: no err pulse, no count.
- O_err_cnt saturates at 255. It is cleared only by I_rst.
- I_rst at any time: all state cleared, including during ALIGNED with FIFO content.

## Timing
- Reset values: O_q*=0, O_vld=0, O_aligned=0, O_align_err=0, O_err_cnt=0, O_lane_skew=0. State = IDLE.
- All outputs are registered. No combinational input→output path.
- O_aligned rises the cycle after the completing SEARCH beat. It falls the cycle after a failure beat or an I_enable deassert.
- O_vld follows each ALIGNED-state I_vld by exactly 1 cycle. The first O_vld beat after alignment carries MARKER on all lanes.
- Latency for lane i word to O_q: (O_lane_skew[i]+1) beats, plus 1 cycle.
- O_align_err is asserted the cycle after the failing beat, for exactly one cycle.

## Test plan
- Zero skew: enable, all lanes MARKER on the same beat, then lane-tagged counter data. Required: O_aligned=1 next cycle; first O_vld shows MARKER on all lanes; O_lane_skew=0; each later row shows equal counter values.
- Skew 2/1/0: lane 3 MARKER two beats late, lane 7 one beat late, others at beat 0, DEPTH=4. Required: aligned after lane 3's marker; skew is 2 on the seven early lanes, 1 on lane 7 and 0 on lane 3; rows equal-valued.
- Overflow: lane 5 MARKER 4 beats after the others. Required: O_align_err pulse one cycle after the fourth beat; O_err_cnt=1; O_aligned stays 0. A following zero-skew marker aligns.
- Broken alignment: after ALIGNED, send MARKER on all lanes except lane 2. Required: that row still output, then err pulse, O_aligned=0, O_err_cnt increments, SEARCH re-entered.
- Gaps/abort: I_vld toggled 1-0-0-1 during SEARCH and ALIGNED, giving identical results to gapless. Drop I_enable with a simultaneous failure: IDLE, no err pulse. Assert I_rst mid-ALIGNED: all outputs at reset values the next cycle.
- Saturation: 260 consecutive overflow failures. Required: O_err_cnt holds at 255.
